rr_arb_mux: RTL

- Read-side counterpart of the general-purpose 1-to-N demux used on memory_col write paths.
- Collects NUM_ELEM element streams, each with its own valid/ready handshake, into one output stream.
- Uses round-robin arbitration and a single registered output stage.
- Reports the index of the source element with each output word, so downstream logic can route responses back through the demux.

---
 rtl/rr_arb_mux_if.sv | 26 ++
 rtl/rr_arb_mux.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: NUM_ELEM element streams in, one tagged stream out.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface rr_arb_mux_if #(
  parameter int NUM_ELEM   = 6,
  parameter int ELEM_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_ELEM);

  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] i_i;
  logic [NUM_ELEM-1:0]                 i_valid_i;
  logic [NUM_ELEM-1:0]                 i_ready_o;
  logic [ELEM_WIDTH-1:0]               o_o;
  logic [SEL_W-1:0]                    o_sel_o;
  logic                                o_valid_o;
  logic                                o_ready_i;

  modport master (
    output i_i, i_valid_i, o_ready_i,
    input  i_ready_o, o_o, o_sel_o, o_valid_o
  );

  modport slave (
    input  i_i, i_valid_i, o_ready_i,
    output i_ready_o, o_o, o_sel_o, o_valid_o
  );
endinterface

// File: rtl/rr_arb_mux.sv
// Round-robin N-to-1 stream mux with one registered output stage and a source-index tag.
// Define RR_ARB_MUX_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module rr_arb_mux #(
  parameter int NUM_ELEM   = 6,
  parameter int ELEM_WIDTH = 8
) (
  input logic          clk_i,
  input logic          arst_ni,
  rr_arb_mux_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_ELEM);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_ELEM - 1);

  // Explicit wrap so the index never leaves 0..NUM_ELEM-1 for non-power-of-two sizes.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return {SEL_W{1'b0}};
    end else begin
      return idx + SEL_W'(1);
    end
  endfunction

  logic [ELEM_WIDTH-1:0] o_r;
  logic [SEL_W-1:0]      sel_r;
  logic                  valid_r;
  logic                  load_en_s;
  logic                  grant_vld_s;
  logic [SEL_W-1:0]      grant_idx_s;
  logic [ELEM_WIDTH-1:0] grant_data_s;
  logic                  xfer_s;

  assign load_en_s = ~valid_r | bus.o_ready_i;
  assign xfer_s    = load_en_s & grant_vld_s;

`ifdef RR_ARB_MUX_FIXED_PRIORITY_EN
  // Grant selection: lowest valid index wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {SEL_W{1'b0}};
    for (int j = NUM_ELEM - 1; j >= 0; j--) begin
      if (bus.i_valid_i[j]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = SEL_W'(j);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end
`else
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] cand_s;

  // Grant selection: first valid index starting at ptr_r, wrapping once around.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {SEL_W{1'b0}};
    cand_s      = ptr_r;
    for (int j = 0; j < NUM_ELEM; j++) begin
      if (!grant_vld_s && bus.i_valid_i[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
      cand_s = next_idx(cand_s);
    end
  end

  // Round-robin pointer: advances past the winner only on an actual transfer.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      ptr_r <= next_idx(grant_idx_s);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Data select for the granted element.
  always_comb begin
    grant_data_s = {ELEM_WIDTH{1'b0}};
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (grant_idx_s == SEL_W'(k)) begin
        grant_data_s = bus.i_i[k];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // One-hot ready towards the granted element when the output stage can accept.
  always_comb begin
    bus.i_ready_o = {NUM_ELEM{1'b0}};
    for (int k = 0; k < NUM_ELEM; k++) begin
      bus.i_ready_o[k] = load_en_s & grant_vld_s & (grant_idx_s == SEL_W'(k));
    end
  end

  // Output stage: load on transfer, clear valid on a drain with no replacement.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      o_r     <= {ELEM_WIDTH{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      valid_r <= 1'b0;
    end else if (xfer_s) begin
      o_r     <= grant_data_s;
      sel_r   <= grant_idx_s;
      valid_r <= 1'b1;
    end else if (valid_r && bus.o_ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign bus.o_o       = o_r;
  assign bus.o_sel_o   = sel_r;
  assign bus.o_valid_o = valid_r;
endmodule
